// File: rtl/upper_immediate_pipeline.sv
// Pipelined LUI/AUIPC result former with a valid/ready handshake, an rd tag
// carried alongside each result, synchronous flush and registered occupancy.
module upper_immediate_pipeline #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [XLEN-1:0]             in_imm_u,
  input  logic [XLEN-1:0]             in_pc,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_result,
  output logic [TAG_W-1:0]            out_tag,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic                        busy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] stageValid;
  logic [XLEN-1:0]   stageData [STAGES];
  logic [TAG_W-1:0]  stageTag  [STAGES];
  logic [STAGES-1:0] adv;
  logic              allFull;
  logic [OCC_W-1:0]  occCount;
  logic              accept;
  logic              retire;
  logic [XLEN-1:0]   immMasked;
  logic [XLEN-1:0]   formed;

  // Advance enables. The recursive rule adv(k) = !v(k) || adv(k+1) is
  // unrolled as: stage k may move unless it and every stage after it are
  // full while the consumer stalls.
  always_comb begin
    allFull = 1'b1;
    adv     = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      allFull               = allFull & stageValid[STAGES-1-i];
      adv[STAGES-1-i]       = out_ready || !allFull;
    end
  end

  // Form the LUI/AUIPC value ahead of the stage-0 register.
  always_comb begin
    immMasked = {in_imm_u[XLEN-1:12], 12'b0};
    formed    = in_mode ? (immMasked + in_pc) : immMasked;
  end

  // Handshake decode.
  always_comb begin
    in_ready = adv[0] && !flush;
    accept   = in_valid && in_ready;
    retire   = stageValid[STAGES-1] && out_ready;
  end

  // Stage registers: flush clears every valid; otherwise each enabled stage
  // takes its predecessor (stage 0 takes the new op or a bubble).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stageValid <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        stageData[k] <= '0;
        stageTag[k]  <= '0;
      end
    end else if (flush) begin
      stageValid <= '0;
    end else begin
      if (adv[0]) begin
        stageValid[0] <= accept;
        if (accept) begin
          stageData[0] <= formed;
          stageTag[0]  <= in_tag;
        end
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          stageValid[k] <= stageValid[k-1];
          if (stageValid[k-1]) begin
            stageData[k] <= stageData[k-1];
            stageTag[k]  <= stageTag[k-1];
          end
        end
      end
    end
  end

  // Registered occupancy tracking accepts and retires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occCount <= '0;
    end else if (flush) begin
      occCount <= '0;
    end else begin
      occCount <= occCount + OCC_W'(accept) - OCC_W'(retire);
    end
  end

  // Output drive from the last stage.
  always_comb begin
    out_valid  = stageValid[STAGES-1];
    out_result = stageData[STAGES-1];
    out_tag    = stageTag[STAGES-1];
    occupancy  = occCount;
    busy       = (occCount != '0);
  end

endmodule
